// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter driving a shared 4:1 mux into one registered valid/ready output.
// Optional per-requester grant counters are enabled with RR_MUX_ARB_STATS_EN.
module rr_mux_arbiter_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_valid,
    input  logic [4*WIDTH-1:0]   in_data,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel
`ifdef RR_MUX_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [4*8-1:0]       grant_cnt
`endif
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 8;

    logic [1:0] ptr;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       found;
    logic       gnt_any;
    logic       can_load;
    logic       xfer;

    assign can_load = ~out_valid | out_ready;
    assign gnt_any  = |in_valid;
    assign xfer     = gnt_any & can_load;

    // Unrolled scan starting at ptr, wrapping 3 -> 0; first valid requester wins.
    always_comb begin
        gnt_idx = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!found && in_valid[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

    // Accept strobe is held low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[32'(gnt_idx)*WIDTH +: WIDTH];
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_MUX_ARB_STATS_EN
    // Saturating per-requester transfer counters; a clear beats a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stats_clr) begin
                    grant_cnt[i*CNT_W +: CNT_W] <= '0;
                end else if (xfer && (gnt_idx == 2'(i)) &&
                             (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed self-checking bench for rr_mux_arbiter_4 (stats checks when RR_MUX_ARB_STATS_EN is defined).
module tb_rr_mux_arbiter_4;

    localparam int unsigned WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
`ifdef RR_MUX_ARB_STATS_EN
    logic               stats_clr;
    logic [31:0]        grant_cnt;
`endif

    int tests_run;
    int tests_failed;

    rr_mux_arbiter_4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef RR_MUX_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_sel"},   32'(out_sel),   32'(s));
        check({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    logic [3:0] exp_rdy;
    logic [3:0] exp_dat;
    logic [15:0] rot_data;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 16'hDCBA;
        out_ready = 1'b1;
        rot_data  = 16'hDCBA;
`ifdef RR_MUX_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #12;
        check_out("reset", 1'b0, 2'd0, 4'h0);
        check("reset_rdy", 32'(in_ready), 32'(4'b0000));
        rst_n = 1'b1;
        #1;

        // All requesters valid: grants rotate 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            exp_dat = rot_data[(k % 4)*4 +: 4];
            check($sformatf("rot%0d_rdy", k), 32'(in_ready), 32'(exp_rdy));
            tick();
            check_out($sformatf("rot%0d", k), 1'b1, 2'(k % 4), exp_dat);
        end

        // Load 5 from requester 1 (ptr=1), then stall three cycles
        in_data = 16'hDC5A;
        #1;
        check("bp_pre_rdy", 32'(in_ready), 32'(4'b0010));
        tick();
        check_out("bp_load", 1'b1, 2'd1, 4'h5);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_rdy", k), 32'(in_ready), 32'(4'b0000));
            tick();
            check_out($sformatf("bp%0d", k), 1'b1, 2'd1, 4'h5);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_rdy", 32'(in_ready), 32'(4'b0100));
        tick();
        check_out("bp_resume", 1'b1, 2'd2, 4'hC);

        // Lone requester 2 granted every cycle (ptr=3 wraps to it)
        in_valid = 4'b0100;
        in_data  = 16'h0700;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("single%0d_rdy", k), 32'(in_ready), 32'(4'b0100));
            tick();
            check_out($sformatf("single%0d", k), 1'b1, 2'd2, 4'h7);
        end

        // One word from requester 1, then idle drain; ptr must end at 2
        in_valid = 4'b0010;
        in_data  = 16'h0090;
        #1;
        check("drain_rdy", 32'(in_ready), 32'(4'b0010));
        tick();
        check_out("drain_load", 1'b1, 2'd1, 4'h9);
        in_valid = 4'b0000;
        tick();
        check_out("drain0", 1'b0, 2'd1, 4'h9);
        tick();
        check_out("drain1", 1'b0, 2'd1, 4'h9);
        in_valid = 4'b1111;
        in_data  = 16'hDCBA;
        #1;
        check("drain_ptr_rdy", 32'(in_ready), 32'(4'b0100));

        // Mid-stream asynchronous reset
        tick();
        check_out("rst_pre", 1'b1, 2'd2, 4'hC);
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 1'b0, 2'd0, 4'h0);
        check("rst_mid_rdy", 32'(in_ready), 32'(4'b0000));
        rst_n = 1'b1;
        #1;
        check("rst_ptr_rdy", 32'(in_ready), 32'(4'b0001));
        in_valid = 4'b1000;
        in_data  = 16'hE000;
        #1;
        check("rst_req3_rdy", 32'(in_ready), 32'(4'b1000));
        tick();
        check_out("rst_req3", 1'b1, 2'd3, 4'hE);
        in_valid = 4'b1111;
        #1;
        check("rst_wrap_rdy", 32'(in_ready), 32'(4'b0001));

`ifdef RR_MUX_ARB_STATS_EN
        in_valid  = 4'b0000;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_clr_all", grant_cnt, 32'h0);
        in_valid = 4'b0001;
        for (int k = 0; k < 300; k++) tick();
        check("stats_sat", grant_cnt, 32'h0000_00FF);
        stats_clr = 1'b1;
        #1;
        check("stats_clr_xfer_rdy", 32'(in_ready), 32'(4'b0001));
        tick();
        stats_clr = 1'b0;
        check("stats_clr_xfer", grant_cnt, 32'h0);
        tick();
        check("stats_inc", grant_cnt, 32'h0000_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter that shares one 4:1 data mux among four valid/ready requesters and drives a single registered output channel.
- Computes the mux select each cycle, transfers the granted requester's word into an output register, and reports which requester the word came from.
- Sits in front of a shared consumer, such as a narrow datapath or an output port, that several producers must take turns driving.

Parameters:
- WIDTH, 4, data width of every requester input and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  bit i = requester i has a word.
- in_data  input  4*WIDTH  packed; requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  one-hot or zero; bit i = requester i's word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  registered data.
- out_sel  output  2  index of the requester that produced out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready=0 is forced combinationally while rst_n is low.
- can_load = ~out_valid | out_ready.
- Grant (combinational):
  - Scan in_valid starting at index ptr, wrapping 3->0.
  - The first set bit is gnt_idx; gnt_any = |in_valid.
- in_ready[i] = gnt_any & can_load & (i==gnt_idx). At most one bit is set.
- Transfer on rising edge when gnt_any & can_load:
  - out_data <= in_data[gnt_idx].
  - out_sel <= gnt_idx.
  - out_valid <= 1.
  - ptr <= gnt_idx+1 (mod 4).
- Drain: out_ready & out_valid & ~gnt_any -> out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid & ~out_ready -> out_data, out_sel, out_valid and ptr all hold; in_ready=0.
- Latency: 1 cycle from an accepted input to out_valid.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous drain and load in the same cycle is a normal back-to-back transfer.
- ptr changes only on a transfer, never on idle cycles. A lone requester is therefore granted every cycle it is valid.
- Fairness: with all four requesters valid continuously, the grant order is 0,1,2,3,0,... Worst-case wait is 3 transfers.
- Requesters must hold in_valid and in_data stable until in_ready. A requester that drops in_valid before in_ready is simply not granted; this is not an error.
- Reset mid-operation: the word in the output register is lost, out_valid drops immediately, and ptr returns to 0.
- Implementation: explicit one-hot rotate/priority logic or a 4-entry unrolled scan; no multicycle paths.

Optional Feature:
- Macro: RR_MUX_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt (4*8 bits, packed like in_data).
  - Holds four 8-bit counters. Counter i increments on each transfer from requester i and saturates at 255.
  - Counters reset to 0 on rst_n low.
  - Adds input stats_clr (1 bit): synchronous clear of all counters. A clear coinciding with a transfer wins; the counter becomes 0.
- Not defined: no grant_cnt and no stats_clr ports, no counter logic. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 and in_ready=0 immediately (asynchronous). After release with only in_valid=4'b1000 -> first transfer goes to requester 3 and ptr becomes 0.
- All valid, out_ready=1, in_data = 4'hA, 4'hB, 4'hC, 4'hD for requesters 0..3 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data A,B,C,D,A; in_ready sequence 0001, 0010, 0100, 1000.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=4'h5 -> out_data stays 4'h5, in_ready=0000, ptr unchanged. After out_ready=1, the next grant follows the saved ptr.
- Single requester: in_valid=4'b0100 for 4 cycles, out_ready=1 -> 4 transfers with out_sel=2 and no idle bubbles.
- Idle drain: a single word from requester 1 followed by in_valid=0 -> out_valid=1 for one cycle, then 0. out_data and out_sel hold; ptr=2.
- RR_MUX_ARB_STATS_EN defined: 300 transfers from requester 0 -> grant_cnt[7:0]=255. Pulsing stats_clr during a transfer -> that counter reads 0 next cycle.
